// File: rtl/mem_branch_sequencer_if.sv
// Bundle of every non-clock signal of mem_branch_sequencer.
//   issue_*    : decode-stage handshake and operands (valid/ready)
//   mem_req_*  : data-memory request channel (valid/ready)
//   mem_rsp_*  : load response (valid only, no backpressure)
//   wb_*       : one-cycle writeback pulse
//   br_*       : one-cycle branch resolution pulse
//   err        : one-cycle error pulse
// Modport master is the sequencer's view; slave is the pipeline/memory side.
interface mem_branch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_inst;
  logic [DATA_WIDTH-1:0] issue_pc;
  logic [DATA_WIDTH-1:0] issue_rs1;
  logic [DATA_WIDTH-1:0] issue_rs2;
  logic [DATA_WIDTH-1:0] issue_offset;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [DATA_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  br_valid;
  logic                  br_taken;
  logic [DATA_WIDTH-1:0] br_target;
  logic                  err;

  modport master (
    input  issue_valid, issue_inst, issue_pc, issue_rs1, issue_rs2, issue_offset,
    output issue_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target, err
  );

  modport slave (
    output issue_valid, issue_inst, issue_pc, issue_rs1, issue_rs2, issue_offset,
    input  issue_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target, err
  );
endinterface

// File: rtl/mem_branch_sequencer.sv
// Multi-cycle sequencer for LOAD/STORE/BRANCH.
// Computes the effective address (rs1 + offset), issues a valid/ready memory
// request, waits for load data with a timeout, and resolves branches.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_branch_sequencer_if.master (issue, memory, wb, branch, err)
module mem_branch_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_branch_sequencer_if.master bus
);
  localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RSP, BR_RES} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, wb_data_q, br_target_q;
  logic [4:0]            rd_q;
  logic                  we_q, wb_valid_q, br_valid_q, br_taken_q, err_q;
  logic                  wb_valid_d, br_valid_d, err_d;
  logic                  cap_req, cap_br, cap_rsp;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  accept, is_mem, is_br, br_cond;
  logic [DATA_WIDTH-1:0] eff_addr, br_tgt;
  logic                  unused_inst;

  assign unused_inst = ^bus.issue_inst[31:15];

  // Decode and address/branch arithmetic on the raw issue inputs; results are
  // captured on acceptance so outputs are registered one cycle later.
  always_comb begin
    opcode   = bus.issue_inst[6:0];
    funct3   = bus.issue_inst[14:12];
    accept   = bus.issue_valid && bus.issue_ready;
    eff_addr = bus.issue_rs1 + bus.issue_offset;
    br_tgt   = bus.issue_pc + (bus.issue_offset << 1);
    is_mem   = ((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == 3'b010);
    is_br    = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
    case (funct3)
      3'b000:  br_cond = (bus.issue_rs1 == bus.issue_rs2);
      3'b001:  br_cond = (bus.issue_rs1 != bus.issue_rs2);
      3'b100:  br_cond = ($signed(bus.issue_rs1) <  $signed(bus.issue_rs2));
      3'b101:  br_cond = ($signed(bus.issue_rs1) >= $signed(bus.issue_rs2));
      3'b110:  br_cond = (bus.issue_rs1 <  bus.issue_rs2);
      3'b111:  br_cond = (bus.issue_rs1 >= bus.issue_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    br_valid_d = 1'b0;
    err_d      = 1'b0;
    cap_req    = 1'b0;
    cap_br     = 1'b0;
    cap_rsp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && (eff_addr[1:0] == 2'b00)) begin
            state_d = MEM_REQ;
            cap_req = 1'b1;
          end else if (is_br) begin
            state_d    = BR_RES;
            br_valid_d = 1'b1;
            cap_br     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = we_q ? IDLE : MEM_RSP;
          cnt_d   = '0;
        end
      end
      MEM_RSP: begin
        // A response in the same cycle the count hits the limit still wins.
        if (bus.mem_rsp_valid) begin
          state_d    = IDLE;
          cap_rsp    = 1'b1;
          wb_valid_d = (rd_q != 5'd0);
        end else if (cnt_q == TMO) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BR_RES:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      wb_valid_q  <= 1'b0;
      br_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      br_valid_q <= br_valid_d;
      err_q      <= err_d;
      if (cap_req) begin
        addr_q  <= eff_addr;
        wdata_q <= bus.issue_rs2;
        we_q    <= (opcode == OP_STORE);
        rd_q    <= bus.issue_inst[11:7];
      end
      if (cap_br) begin
        br_taken_q  <= br_cond;
        br_target_q <= br_tgt;
      end
      if (cap_rsp) begin
        wb_data_q <= bus.mem_rsp_rdata;
      end
    end
  end

  assign bus.issue_ready   = (state_q == IDLE) && !rst;
  assign bus.mem_req_valid = (state_q == MEM_REQ);
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.br_valid      = br_valid_q;
  assign bus.br_taken      = br_taken_q;
  assign bus.br_target     = br_target_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_branch_sequencer.sv
// Self-checking bench for mem_branch_sequencer (TIMEOUT_CYCLES = 4).
module tb_mem_branch_sequencer;
  localparam int K_ERR = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mem_branch_sequencer_if #(.DATA_WIDTH(32)) bus ();

  mem_branch_sequencer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what an instruction should do, from the opcode/funct3 rules.
  function automatic int model_kind(input logic [31:0] inst, input logic [31:0] ea);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = inst[6:0];
    f3  = inst[14:12];
    if (opc == 7'b0000011 && f3 == 3'd2 && (ea % 4) == 0) return K_LOAD;
    if (opc == 7'b0100011 && f3 == 3'd2 && (ea % 4) == 0) return K_STORE;
    if (opc == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) return K_BR;
    return K_ERR;
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'(a) - ((a >= 32'h8000_0000) ? 64'sd4294967296 : 64'sd0);
    sb = longint'(b) - ((b >= 32'h8000_0000) ? 64'sd4294967296 : 64'sd0);
    ua = longint'(a);
    ub = longint'(b);
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa <  sb;
      3'd5: return sa >= sb;
      3'd6: return ua <  ub;
      default: return ua >= ub;
    endcase
  endfunction

  // Drives one instruction from IDLE and checks every cycle until back in IDLE.
  task automatic do_inst(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] off, input int unsigned req_wait,
                         input int unsigned rsp_wait, input logic [31:0] rdata, input string tag);
    logic [31:0] ea, tgt;
    logic [4:0]  rd;
    logic        tk;
    int          kind;
    ea   = rs1 + off;
    tgt  = pc + off * 32'd2;
    rd   = inst[11:7];
    tk   = model_taken(inst[14:12], rs1, rs2);
    kind = model_kind(inst, ea);

    checks++;
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL %s ready_at_issue got=%0b exp=1", tag, bus.issue_ready); end
    bus.issue_valid = 1'b1; bus.issue_inst = inst; bus.issue_pc = pc;
    bus.issue_rs1 = rs1; bus.issue_rs2 = rs2; bus.issue_offset = off;
    step();
    bus.issue_valid = 1'b0; bus.issue_inst = $urandom; bus.issue_pc = $urandom;
    bus.issue_rs1 = $urandom; bus.issue_rs2 = $urandom; bus.issue_offset = $urandom;

    if (kind == K_ERR) begin
      checks++;
      if ({bus.err, bus.mem_req_valid, bus.wb_valid, bus.br_valid} !== 4'b1000) begin
        failures++; $display("FAIL %s err_pulse got=%b exp=1000", tag, {bus.err, bus.mem_req_valid, bus.wb_valid, bus.br_valid});
      end
      checks++;
      if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL %s err_ready got=%0b exp=1", tag, bus.issue_ready); end
      step();
      checks++;
      if ({bus.err, bus.mem_req_valid} !== 2'b00) begin failures++; $display("FAIL %s err_after got=%b exp=00", tag, {bus.err, bus.mem_req_valid}); end
    end else if (kind == K_BR) begin
      checks++;
      if ({bus.br_valid, bus.wb_valid, bus.err, bus.issue_ready, bus.mem_req_valid} !== 5'b10000) begin
        failures++; $display("FAIL %s br_pulse got=%b exp=10000", tag, {bus.br_valid, bus.wb_valid, bus.err, bus.issue_ready, bus.mem_req_valid});
      end
      checks++;
      if (bus.br_taken !== tk) begin failures++; $display("FAIL %s br_taken got=%0b exp=%0b", tag, bus.br_taken, tk); end
      checks++;
      if (bus.br_target !== tgt) begin failures++; $display("FAIL %s br_target got=%h exp=%h", tag, bus.br_target, tgt); end
      bus.issue_valid = 1'($urandom_range(0, 1));
      step();
      bus.issue_valid = 1'b0;
      checks++;
      if ({bus.br_valid, bus.issue_ready} !== 2'b01) begin failures++; $display("FAIL %s br_end got=%b exp=01", tag, {bus.br_valid, bus.issue_ready}); end
    end else begin
      for (int unsigned w = 0; w <= req_wait; w++) begin
        checks++;
        if ({bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.br_valid, bus.err} !== 5'b10000) begin
          failures++; $display("FAIL %s req_ctl w=%0d got=%b exp=10000", tag, w, {bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.br_valid, bus.err});
        end
        checks++;
        if (bus.mem_req_addr !== ea) begin failures++; $display("FAIL %s req_addr w=%0d got=%h exp=%h", tag, w, bus.mem_req_addr, ea); end
        checks++;
        if (bus.mem_req_we !== (kind == K_STORE)) begin failures++; $display("FAIL %s req_we got=%0b exp=%0b", tag, bus.mem_req_we, kind == K_STORE); end
        if (kind == K_STORE) begin
          checks++;
          if (bus.mem_req_wdata !== rs2) begin failures++; $display("FAIL %s req_wdata got=%h exp=%h", tag, bus.mem_req_wdata, rs2); end
        end
        bus.mem_req_ready = (w == req_wait);
        bus.mem_rsp_valid = 1'($urandom_range(0, 1));
        bus.mem_rsp_rdata = $urandom;
        bus.issue_valid   = 1'($urandom_range(0, 1));
        step();
      end
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.issue_valid = 1'b0;
      if (kind == K_STORE) begin
        checks++;
        if ({bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.err} !== 4'b0100) begin
          failures++; $display("FAIL %s store_end got=%b exp=0100", tag, {bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.err});
        end
      end else begin
        for (int unsigned w = 0; w <= rsp_wait; w++) begin
          checks++;
          if ({bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.err} !== 4'b0000) begin
            failures++; $display("FAIL %s rsp_wait w=%0d got=%b exp=0000", tag, w, {bus.mem_req_valid, bus.issue_ready, bus.wb_valid, bus.err});
          end
          bus.mem_rsp_valid = (w == rsp_wait);
          bus.mem_rsp_rdata = (w == rsp_wait) ? rdata : $urandom;
          bus.issue_valid   = 1'($urandom_range(0, 1));
          step();
        end
        bus.mem_rsp_valid = 1'b0; bus.issue_valid = 1'b0;
        checks++;
        if ({bus.wb_valid, bus.issue_ready, bus.err, bus.br_valid} !== {rd != 5'd0, 3'b100}) begin
          failures++; $display("FAIL %s wb_pulse got=%b exp=%b", tag, {bus.wb_valid, bus.issue_ready, bus.err, bus.br_valid}, {rd != 5'd0, 3'b100});
        end
        if (rd != 5'd0) begin
          checks++;
          if (bus.wb_rd !== rd) begin failures++; $display("FAIL %s wb_rd got=%0d exp=%0d", tag, bus.wb_rd, rd); end
          checks++;
          if (bus.wb_data !== rdata) begin failures++; $display("FAIL %s wb_data got=%h exp=%h", tag, bus.wb_data, rdata); end
        end
        step();
        checks++;
        if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL %s wb_single got=%0b exp=0", tag, bus.wb_valid); end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_inst = 32'h0000_2283; bus.issue_pc = '0;
    bus.issue_rs1 = 32'h100; bus.issue_rs2 = '0; bus.issue_offset = '0;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h1234;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.issue_ready, bus.mem_req_valid, bus.mem_req_we, bus.wb_valid, bus.br_valid, bus.br_taken, bus.err} !== 7'b0) begin
        failures++; $display("FAIL reset_ctl got=%b exp=0000000", {bus.issue_ready, bus.mem_req_valid, bus.mem_req_we, bus.wb_valid, bus.br_valid, bus.br_taken, bus.err});
      end
      checks++;
      if ((bus.mem_req_addr | bus.mem_req_wdata | bus.wb_data | bus.br_target | {27'b0, bus.wb_rd}) !== 32'h0) begin
        failures++; $display("FAIL reset_data got=%h exp=0", bus.mem_req_addr | bus.mem_req_wdata | bus.wb_data | bus.br_target);
      end
      step();
    end
    bus.issue_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", bus.issue_ready); end
    step();
  endtask

  task automatic test_load();
    do_inst({17'b0, 3'b010, 5'd5, 7'b0000011}, 32'h0, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC, 3, 0, 32'hDEAD_BEEF, "load");
    checks++;
    if (bus.wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_wb_hold got=%h exp=deadbeef", bus.wb_data); end
  endtask

  task automatic test_store();
    do_inst({17'b0, 3'b010, 5'd8, 7'b0100011}, 32'h0, 32'h20, 32'hA5A5_A5A5, 32'h8, 0, 0, 32'h0, "store");
    checks++;
    if (bus.mem_req_addr !== 32'h28) begin failures++; $display("FAIL store_addr got=%h exp=28", bus.mem_req_addr); end
  endtask

  task automatic test_branch();
    do_inst({17'b0, 3'b100, 5'd0, 7'b1100011}, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 0, 0, 32'h0, "blt");
    checks++;
    if ({bus.br_taken, bus.br_target} !== {1'b1, 32'h0000_00F0}) begin
      failures++; $display("FAIL blt_hold got=%b/%h exp=1/000000f0", bus.br_taken, bus.br_target);
    end
    do_inst({17'b0, 3'b110, 5'd0, 7'b1100011}, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 0, 0, 32'h0, "bltu");
    checks++;
    if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL bltu_hold got=%0b exp=0", bus.br_taken); end
  endtask

  task automatic test_errors();
    do_inst(32'h0000_0033, 32'h0, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0, "bad_opcode");
    do_inst({17'b0, 3'b010, 5'd3, 7'b0000011}, 32'h0, 32'h1000, 32'h0, 32'h2, 0, 0, 32'h0, "misaligned");
    do_inst({17'b0, 3'b000, 5'd3, 7'b0000011}, 32'h0, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0, "bad_funct3");
  endtask

  task automatic test_timeout();
    bus.issue_valid = 1'b1; bus.issue_inst = {17'b0, 3'b010, 5'd9, 7'b0000011};
    bus.issue_rs1 = 32'h2000; bus.issue_offset = 32'h4; bus.issue_rs2 = '0; bus.issue_pc = '0;
    step();
    bus.issue_valid = 1'b0; bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    // Count sits at 0..4 over these five cycles; err follows the cycle at 4.
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if ({bus.err, bus.issue_ready, bus.wb_valid} !== 3'b000) begin
        failures++; $display("FAIL timeout_wait i=%0d got=%b exp=000", i, {bus.err, bus.issue_ready, bus.wb_valid});
      end
      step();
    end
    checks++;
    if ({bus.err, bus.issue_ready, bus.wb_valid} !== 3'b110) begin
      failures++; $display("FAIL timeout_err got=%b exp=110", {bus.err, bus.issue_ready, bus.wb_valid});
    end
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.err, bus.wb_valid, bus.issue_ready} !== 3'b001) begin
        failures++; $display("FAIL timeout_late_rsp i=%0d got=%b exp=001", i, {bus.err, bus.wb_valid, bus.issue_ready});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bus.issue_valid = 1'b1; bus.issue_inst = {17'b0, 3'b010, 5'd7, 7'b0000011};
    bus.issue_rs1 = 32'h4000; bus.issue_offset = 32'h10; bus.issue_rs2 = 32'h55; bus.issue_pc = '0;
    step();
    bus.issue_valid = 1'b0; bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.issue_ready, bus.mem_req_valid, bus.mem_req_we, bus.wb_valid, bus.br_valid, bus.br_taken, bus.err} !== 7'b0) begin
      failures++; $display("FAIL midrst_ctl got=%b exp=0000000", {bus.issue_ready, bus.mem_req_valid, bus.mem_req_we, bus.wb_valid, bus.br_valid, bus.br_taken, bus.err});
    end
    checks++;
    if ((bus.mem_req_addr | bus.mem_req_wdata | bus.wb_data | bus.br_target | {27'b0, bus.wb_rd}) !== 32'h0) begin
      failures++; $display("FAIL midrst_data got=%h exp=0", bus.mem_req_addr | bus.mem_req_wdata | bus.wb_data | bus.br_target);
    end
    step();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h7777_7777;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.issue_ready, bus.err, bus.wb_valid, bus.mem_req_valid} !== 4'b1000) begin
        failures++; $display("FAIL midrst_after i=%0d got=%b exp=1000", i, {bus.issue_ready, bus.err, bus.wb_valid, bus.mem_req_valid});
      end
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    do_inst({17'b0, 3'b010, 5'd7, 7'b0000011}, 32'h0, 32'h4000, 32'h0, 32'h10, 1, 2, 32'h1357_9BDF, "post_reset_load");
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] inst, pc, rs1, rs2, off, ea;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int unsigned cls;
    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 9);
      rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      pc  = $urandom;
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      off = {{20{1'b0}}, 12'($urandom)};
      if (off[11]) off = off | 32'hFFFF_F000;
      if (cls <= 4) begin
        f3 = (cls == 4 && $urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b010;
        if ($urandom_range(0, 3) != 0) begin
          ea  = rs1 + off;
          rs1 = rs1 - {30'b0, ea[1:0]};
        end
        inst = {17'($urandom), f3, rd, (cls <= 2) ? 7'b0000011 : 7'b0100011};
      end else if (cls <= 8) begin
        inst = {17'($urandom), 3'($urandom), rd, 7'b1100011};
      end else begin
        inst = {25'($urandom), 7'($urandom)};
      end
      do_inst(inst, pc, rs1, rs2, off, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_inst = '0; bus.issue_pc = '0; bus.issue_rs1 = '0;
    bus.issue_rs2 = '0; bus.issue_offset = '0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_errors();
    test_timeout();
    test_random_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
